// File: rtl/imu_quat_bracket_selector.sv
// imu_quat_bracket_selector: ring-buffers timestamped Q16.16 IMU quaternions and,
// for each target timestamp, returns the bracketing sample pair plus the
// Q16.16 interpolation fraction for the downstream SLERP stage.
// Optional feature macro: QUAT_HEMI_FIX_EN (negates q2 when dot(q1,q2) < 0).
module imu_quat_bracket_selector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imu_valid,
    output logic              imu_ready,
    input  logic [0:3][31:0]  imu_q,
    input  logic [TS_W-1:0]   imu_ts,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [TS_W-1:0]   req_ts,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:3][31:0]  q1,
    output logic [0:3][31:0]  q2,
    output logic [31:0]       t,
    output logic [1:0]        status,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REM_W = TS_W + 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_DIVIDE,
`ifdef QUAT_HEMI_FIX_EN
        S_HEMI,
`endif
        S_OUT
    } state_t;

    state_t                  state_q, state_d;
    logic [0:3][31:0]        smp_quat_q [DEPTH];
    logic [0:3][31:0]        smp_quat_d [DEPTH];
    logic [TS_W-1:0]         smp_ts_q   [DEPTH];
    logic [TS_W-1:0]         smp_ts_d   [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [7:0]              drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0]        scan_q, scan_d;
    logic [TS_W-1:0]         req_ts_q, req_ts_d;
    logic [REM_W-1:0]        rem_q, rem_d;
    logic [TS_W-1:0]         den_q, den_d;
    logic [3:0]              div_cnt_q, div_cnt_d;
    logic [0:3][31:0]        q1_q, q1_d, q2_q, q2_d;
    logic [31:0]             t_q, t_d;
    logic [1:0]              status_q, status_d;
    logic                    out_valid_q, out_valid_d;
    logic                    imu_ready_q, imu_ready_d;
    logic                    req_ready_q, req_ready_d;

    logic [PTR_W-1:0]        newest_idx, oldest_idx, cur_idx, nxt_idx;
    logic [REM_W-1:0]        rem_shift, den_ext;

    assign newest_idx = wr_ptr_q - PTR_W'(1);
    assign oldest_idx = wr_ptr_q - count_q[PTR_W-1:0];
    assign cur_idx    = oldest_idx + scan_q;
    assign nxt_idx    = cur_idx + PTR_W'(1);
    assign rem_shift  = {rem_q[REM_W-2:0], 1'b0};
    assign den_ext    = REM_W'(den_q);

`ifdef QUAT_HEMI_FIX_EN
    logic signed [63:0] dot;

    // 64-bit accumulated dot product of the latched bracket pair
    always_comb begin
        dot = '0;
        for (int k = 0; k < 4; k++) begin
            dot = dot + 64'($signed(q1_q[k])) * 64'($signed(q2_q[k]));
        end
    end
`endif

    // Sample buffer write: append monotonic samples, overwrite oldest when full
    always_comb begin
        smp_quat_d = smp_quat_q;
        smp_ts_d   = smp_ts_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (imu_valid && imu_ready_q) begin
            if ((count_q != '0) && (imu_ts <= smp_ts_q[newest_idx])) begin
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end else begin
                smp_quat_d[wr_ptr_q] = imu_q;
                smp_ts_d[wr_ptr_q]   = imu_ts;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
                if (count_q != CNT_W'(DEPTH)) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        end
    end

    // Request FSM: search bracket, divide for fraction, present result
    always_comb begin
        state_d   = state_q;
        scan_d    = scan_q;
        req_ts_d  = req_ts_q;
        rem_d     = rem_q;
        den_d     = den_q;
        div_cnt_d = div_cnt_q;
        q1_d      = q1_q;
        q2_d      = q2_q;
        t_d       = t_q;
        status_d  = status_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ts_d = req_ts;
                    // emptiness is judged after a same-cycle write commits
                    if (count_d == '0) begin
                        q1_d     = '0;
                        q2_d     = '0;
                        t_d      = '0;
                        status_d = 2'b11;
                        state_d  = S_OUT;
                    end else begin
                        scan_d  = '0;
                        state_d = S_SEARCH;
                    end
                end
            end
            S_SEARCH: begin
                if ((scan_q == '0) && (req_ts_q < smp_ts_q[cur_idx])) begin
                    q1_d     = smp_quat_q[cur_idx];
                    q2_d     = smp_quat_q[cur_idx];
                    t_d      = '0;
                    status_d = 2'b01;
                    state_d  = S_OUT;
                end else if (CNT_W'(scan_q) == (count_q - CNT_W'(1))) begin
                    q1_d     = smp_quat_q[cur_idx];
                    q2_d     = smp_quat_q[cur_idx];
                    t_d      = '0;
                    status_d = 2'b10;
                    state_d  = S_OUT;
                end else if (req_ts_q < smp_ts_q[nxt_idx]) begin
                    q1_d      = smp_quat_q[cur_idx];
                    q2_d      = smp_quat_q[nxt_idx];
                    rem_d     = REM_W'(req_ts_q - smp_ts_q[cur_idx]);
                    den_d     = smp_ts_q[nxt_idx] - smp_ts_q[cur_idx];
                    div_cnt_d = '0;
                    t_d       = '0;
                    status_d  = 2'b00;
                    state_d   = S_DIVIDE;
                end else begin
                    scan_d = scan_q + PTR_W'(1);
                end
            end
            S_DIVIDE: begin
                // restoring division, one quotient bit per cycle, MSB first
                if (rem_shift >= den_ext) begin
                    rem_d = rem_shift - den_ext;
                    t_d   = {t_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift;
                    t_d   = {t_q[30:0], 1'b0};
                end
                div_cnt_d = div_cnt_q + 4'd1;
                if (div_cnt_q == 4'd15) begin
`ifdef QUAT_HEMI_FIX_EN
                    state_d = S_HEMI;
`else
                    state_d = S_OUT;
`endif
                end
            end
`ifdef QUAT_HEMI_FIX_EN
            S_HEMI: begin
                if (dot[63]) begin
                    for (int k = 0; k < 4; k++) begin
                        q2_d[k] = -q2_q[k];
                    end
                end
                state_d = S_OUT;
            end
`endif
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state
    always_comb begin
        out_valid_d = (state_d == S_OUT);
        imu_ready_d = (state_d != S_SEARCH);
        req_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            smp_quat_q  <= '{default: '0};
            smp_ts_q    <= '{default: '0};
            wr_ptr_q    <= '0;
            count_q     <= '0;
            drop_cnt_q  <= '0;
            scan_q      <= '0;
            req_ts_q    <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            div_cnt_q   <= '0;
            q1_q        <= '0;
            q2_q        <= '0;
            t_q         <= '0;
            status_q    <= '0;
            out_valid_q <= 1'b0;
            imu_ready_q <= 1'b1;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            smp_quat_q  <= smp_quat_d;
            smp_ts_q    <= smp_ts_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            drop_cnt_q  <= drop_cnt_d;
            scan_q      <= scan_d;
            req_ts_q    <= req_ts_d;
            rem_q       <= rem_d;
            den_q       <= den_d;
            div_cnt_q   <= div_cnt_d;
            q1_q        <= q1_d;
            q2_q        <= q2_d;
            t_q         <= t_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
            imu_ready_q <= imu_ready_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign imu_ready = imu_ready_q;
    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign q1        = q1_q;
    assign q2        = q2_q;
    assign t         = t_q;
    assign status    = status_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/imu_quat_bracket_selector.md
Name: imu_quat_bracket_selector

Overview:
Upstream feeder for the SLERP stage of the IMU synchronizer. It buffers timestamped IMU quaternion samples (Q16.16) in a ring buffer. For each target timestamp request it finds the two samples that bracket the target. It emits q1, q2 and the Q16.16 interpolation fraction t, which map directly onto the SLERP calculator's q1/q2/t inputs.

Parameters:
DEPTH, 8, ring-buffer entries (power of 2, ≥2)
TS_W, 32, timestamp width in ticks (unsigned)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
imu_valid  input  1  sample-write strobe
imu_ready  output  1  sample write accepted when high
imu_q  input  4x32  sample quaternion [0:3], Q16.16
imu_ts  input  TS_W  sample timestamp
req_valid  input  1  interpolation request
req_ready  output  1  request accepted when high
req_ts  input  TS_W  target timestamp
out_valid  output  1  result valid
out_ready  input  1  consumer ready
q1  output  4x32  earlier bracket sample
q2  output  4x32  later bracket sample
t  output  32  Q16.16 fraction, 0x00000000..0x0000FFFF
status  output  2  00 bracketed, 01 before-oldest, 10 at/after-newest, 11 empty
drop_cnt  output  8  saturating count of rejected non-monotonic samples

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset values: buffer count=0, wr_ptr=0, FSM=IDLE, imu_ready=1, req_ready=1, out_valid=0, q1=q2=0, t=0, status=00, drop_cnt=0.
- Write handshake: a sample is written when imu_valid && imu_ready.
  - imu_ready=0 only in SEARCH; it is 1 in all other states.
  - When the buffer is full, a write overwrites the oldest entry and the oldest pointer advances.
  - A sample with imu_ts <= newest stored ts (count>0) is discarded, not stored, and drop_cnt increments (saturates at 255).
- FSM states: IDLE, SEARCH, DIVIDE, OUT.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_ts.
  - count==0: load q=0, t=0, status=11, go to OUT.
  - Otherwise go to SEARCH with scan index = oldest.
- SEARCH: one entry pair per cycle, oldest to newest.
  - req_ts < ts[oldest]: q1=q2=oldest sample, t=0, status=01, go to OUT.
  - First i with ts[i] <= req_ts < ts[i+1]: latch q1=s[i], q2=s[i+1], num=req_ts-ts[i], den=ts[i+1]-ts[i], status=00, go to DIVIDE.
  - Scan reaches newest (req_ts >= ts[newest], or count==1): q1=q2=newest, t=0, status=10, go to OUT.
- DIVIDE: 16-cycle restoring divider computes t = floor((num<<16)/den).
  - num<den guarantees t<0x10000.
  - num==0 yields t=0.
  - Use TS_W+17-bit internal remainder; no overflow permitted.
- OUT:
  - out_valid=1; outputs held stable until out_ready.
  - On out_valid && out_ready, out_valid drops next cycle and FSM returns to IDLE.
- req_ready=0 outside IDLE.
- Latency from request acceptance to out_valid: 1 + k search cycles (k ≤ DEPTH) + 16 divide cycles for bracketed results. Clamped and empty results skip DIVIDE.
- Simultaneous imu write and req in IDLE: the write commits first. The request sees the buffer including the new sample, provided the request enters SEARCH on the following cycle.
- Reset mid-operation returns all state to reset values, discards the pending request and clears the buffer.

Optional Feature:
QUAT_HEMI_FIX_EN.
- Defined: on entering OUT with status 00, if the sign of the 64-bit accumulated dot(q1,q2) is negative, q2 is replaced by -q2 (two's complement of each component). This adds one cycle before OUT.
- Undefined: q2 is passed unmodified and there is no extra cycle.

Test Plan:
- Write samples ts=100 and ts=200, then req_ts=150 → status=00, q1/q2 = those samples, t=0x00008000, out_valid 1+2+16 cycles after acceptance (±1 for scan position).
- Same buffer, req_ts=50 → status=01, q1=q2=sample@100, t=0; req_ts=250 → status=10, q1=q2=sample@200, t=0.
- Empty buffer, req_ts=10 → status=11, q1=q2=0, t=0.
- Write 10 samples ts=10,20..100 with DEPTH=8, then req_ts=25 → status=01 (oldest ts is now 30); req_ts=95 → t=0x00008000.
- Write ts=100 then ts=90 → drop_cnt=1, buffer unchanged; hold out_ready=0 for 5 cycles → outputs stable, req_ready=0.
- With QUAT_HEMI_FIX_EN: q1=(1.0,0,0,0), q2=(-1.0,0,0,0) → q2 output (0x00010000,0,0,0).
